// File: rtl/apb_master_ctrl.sv
// APB master controller: takes one application command at a time, runs the
// APB SETUP/ACCESS sequence with a bounded PREADY wait, and returns a response.
module apb_master_ctrl #(
  parameter int DATA_WD = 32,
  parameter int ADDR_WD = 16,
  parameter int TIMEOUT = 255
) (
  input  logic               PCLK,
  input  logic               PRESETn,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic               cmd_write,
  input  logic [ADDR_WD-1:0] cmd_addr,
  input  logic [DATA_WD-1:0] cmd_wdata,
  input  logic [3:0]         cmd_strb,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_WD-1:0] rsp_rdata,
  output logic [1:0]         rsp_err,
  output logic               rsp_timeout,
  output logic               PSEL,
  output logic               PENABLE,
  output logic               PWRITE,
  output logic [ADDR_WD-1:0] PADDR,
  output logic [DATA_WD-1:0] PWDATA,
  output logic [3:0]         PSTRB,
  input  logic               PREADY,
  input  logic [DATA_WD-1:0] PRDATA,
  input  logic [1:0]         PSLVERR
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t             state_q, state_d;
  logic [7:0]         wait_cnt_q, wait_cnt_d;

  logic               cmd_ready_d;
  logic               rsp_valid_d;
  logic [DATA_WD-1:0] rsp_rdata_d;
  logic [1:0]         rsp_err_d;
  logic               rsp_timeout_d;
  logic               psel_d;
  logic               penable_d;
  logic               pwrite_d;
  logic [ADDR_WD-1:0] paddr_d;
  logic [DATA_WD-1:0] pwdata_d;
  logic [3:0]         pstrb_d;

  always_comb begin
    // NOTE: every signal gets a hold-value default first so no branch can leave
    // it unassigned, which would otherwise infer a latch.
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    cmd_ready_d   = cmd_ready;
    rsp_valid_d   = rsp_valid;
    rsp_rdata_d   = rsp_rdata;
    rsp_err_d     = rsp_err;
    rsp_timeout_d = rsp_timeout;
    psel_d        = PSEL;
    penable_d     = PENABLE;
    pwrite_d      = PWRITE;
    paddr_d       = PADDR;
    pwdata_d      = PWDATA;
    pstrb_d       = PSTRB;

    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          // The APB address/data registers double as the latched command.
          paddr_d     = cmd_addr;
          pwrite_d    = cmd_write;
          pwdata_d    = cmd_write ? cmd_wdata : '0;
          pstrb_d     = cmd_write ? cmd_strb : 4'h0;
          cmd_ready_d = 1'b0;
          psel_d      = 1'b1;
          wait_cnt_d  = 8'd0;
          state_d     = ST_SETUP;
        end
      end

      ST_SETUP: begin
        penable_d = 1'b1;
        state_d   = ST_ACCESS;
      end

      ST_ACCESS: begin
        if (PREADY) begin
          rsp_err_d     = PSLVERR;
          rsp_rdata_d   = PWRITE ? '0 : PRDATA;
          rsp_timeout_d = 1'b0;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = ST_RESP;
        end else if (wait_cnt_q == TIMEOUT_CNT - 8'd1) begin
          // This low sample is the TIMEOUT-th in a row: abort the transfer.
          rsp_err_d     = 2'b00;
          rsp_rdata_d   = '0;
          rsp_timeout_d = 1'b1;
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = ST_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      ST_RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      cmd_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 2'b00;
      rsp_timeout <= 1'b0;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      PSTRB       <= 4'h0;
    end else begin
      cmd_ready   <= cmd_ready_d;
      rsp_valid   <= rsp_valid_d;
      rsp_rdata   <= rsp_rdata_d;
      rsp_err     <= rsp_err_d;
      rsp_timeout <= rsp_timeout_d;
      PSEL        <= psel_d;
      PENABLE     <= penable_d;
      PWRITE      <= pwrite_d;
      PADDR       <= paddr_d;
      PWDATA      <= pwdata_d;
      PSTRB       <= pstrb_d;
    end
  end

endmodule

// File: doc/apb_master_ctrl.md
# apb_master_ctrl

APB master controller that sits directly upstream of the APB slave and drives its PSEL/PENABLE/PWRITE/PADDR/PWDATA/PSTRB bus. It accepts one command at a time from the application over a valid/ready handshake, sequences the APB SETUP and ACCESS phases, and waits on PREADY with a bounded wait-state timeout. It returns read data, the 2-bit PSLVERR code, and a timeout flag on a response handshake.

## Interface
Parameters:
- DATA_WD, 32, data bus width
- ADDR_WD, 16, address bus width
- TIMEOUT, 255, maximum consecutive PREADY-low samples in ACCESS before abort (legal range 1..255)

Ports:
- PCLK  in  1  single clock; all logic on rising edge
- PRESETn  in  1  asynchronous, active-low reset
- cmd_valid  in  1  application command present
- cmd_ready  out  1  controller can accept a command
- cmd_write  in  1  1 = write, 0 = read
- cmd_addr  in  ADDR_WD  target address
- cmd_wdata  in  DATA_WD  write data
- cmd_strb  in  4  write byte strobes
- rsp_valid  out  1  response available
- rsp_ready  in  1  application consumes response
- rsp_rdata  out  DATA_WD  read data
- rsp_err  out  2  captured PSLVERR {parity, address}
- rsp_timeout  out  1  transfer aborted by timeout
- PSEL, PENABLE, PWRITE  out  1 each  APB control
- PADDR  out  ADDR_WD; PWDATA  out  DATA_WD; PSTRB  out  4
- PREADY  in  1; PRDATA  in  DATA_WD; PSLVERR  in  2

## Operation
- All outputs are registered. Reset values: cmd_ready=1; all other outputs 0.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready=1, PSEL=PENABLE=0. On cmd_valid&cmd_ready: latch command, drive PADDR/PWRITE; PWDATA=cmd_wdata and PSTRB=cmd_strb for writes, PWDATA=0 and PSTRB=0 for reads; cmd_ready->0; go SETUP.
- SETUP: PSEL=1, PENABLE=0, exactly one cycle; go ACCESS.
- ACCESS: PSEL=1, PENABLE=1. Each edge samples PREADY:
  - PREADY=1: capture rsp_err=PSLVERR; rsp_rdata=PRDATA for reads, 0 for writes; rsp_timeout=0; PSEL=PENABLE=0; rsp_valid=1; go RESP.
  - PREADY=0: wait counter +1. On the TIMEOUT-th consecutive low sample: rsp_timeout=1, rsp_err=0, rsp_rdata=0, PSEL=PENABLE=0, rsp_valid=1, go RESP.
- Wait counter: 8 bits, cleared on entry to SETUP; never wraps (abort precedes overflow).
- RESP: rsp_valid and rsp_* held stable until rsp_valid&rsp_ready at an edge; then rsp_valid=0, cmd_ready=1, go IDLE.
- PADDR/PWRITE/PWDATA/PSTRB are stable from SETUP through the completing ACCESS edge; they hold their last value in RESP/IDLE until the next accepted command.
- cmd_valid while cmd_ready=0 is ignored; the command is not latched.
- PSLVERR is sampled only on the PREADY=1 edge and ignored otherwise.
- PRESETn assertion at any time: immediate return to IDLE with reset output values. An in-flight transfer is dropped and no response is generated.

## Timing
- Command accepted at edge N -> PSEL=1 after N; PENABLE=1 after N+1.
- Zero-wait slave (PREADY=1 at N+2): rsp_valid=1 after N+2. Minimum command-to-response latency is 2 cycles.
- Each PREADY-low sample adds one cycle.
- Response consumed at edge M -> cmd_ready=1 after M. Next accept earliest at M+1. Back-to-back throughput is 4 cycles per transfer with a zero-wait slave and rsp_ready held high.
- Timeout with PREADY stuck low: rsp_valid=1 after edge N+1+TIMEOUT.
- PENABLE never asserts without PSEL. PSEL deasserts in the same cycle rsp_valid rises.

## Test plan
- Reset: hold PRESETn=0 -> cmd_ready=1, all APB outputs 0, rsp_valid=0. Release -> state unchanged until cmd_valid.
- Zero-wait write: addr 0x0010, wdata 0xDEADBEEF, strb 0xF; PREADY=1 -> PSEL at N+1, PENABLE at N+2, rsp_valid after N+2 with rsp_err=0, rsp_rdata=0, rsp_timeout=0.
- Read with 3 wait states: addr 0x0020, PRDATA=0x12345678, PREADY high on 4th ACCESS sample -> rsp_valid after N+5, rsp_rdata=0x12345678, PSTRB=0 throughout, PADDR stable.
- Error capture: read with PREADY=1 and PSLVERR=2'b10 -> rsp_err=2'b10. PSLVERR=2'b11 on wait-state cycles only -> rsp_err=0.
- Timeout with TIMEOUT=4: PREADY stuck 0 -> rsp_valid after N+5, rsp_timeout=1, rsp_rdata=0, PSEL=PENABLE=0. Then rsp_ready held 0 for 3 cycles -> rsp_* stable. Then rsp_ready=1 -> cmd_ready=1.
- Reset during ACCESS: assert PRESETn=0 mid-wait -> PSEL/PENABLE drop immediately, no rsp_valid after release, next command completes normally.
